// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command path: opcode values, dispatcher
// state encoding and the opcode legality test. Also imported by the
// image controller, so opcode values must not move.
package lcd_pkg;

    localparam int unsigned OPCODE_W = 4;

    // Host command opcodes understood by the image controller.
    typedef enum logic [OPCODE_W-1:0] {
        OP_WRITE       = 4'd0,
        OP_SHIFT_UP    = 4'd1,
        OP_SHIFT_DOWN  = 4'd2,
        OP_SHIFT_LEFT  = 4'd3,
        OP_SHIFT_RIGHT = 4'd4,
        OP_ROTATE_CW   = 4'd5,
        OP_ROTATE_CCW  = 4'd6,
        OP_INVERT      = 4'd7,
        OP_BRIGHT_UP   = 4'd8,
        OP_BRIGHT_DOWN = 4'd9,
        OP_MIRROR_X    = 4'd10,
        OP_MIRROR_Y    = 4'd11
    } lcd_opcode_e;

    localparam logic [OPCODE_W-1:0] MAX_OPCODE = 4'd11;

    // Dispatcher FSM states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_GUARD     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } lcd_state_e;

    // Opcodes 12..15 are reserved and must never reach the controller.
    function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
        return (op <= MAX_OPCODE);
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command queue. DEPTH must be a power of two so the pointers
// wrap from DEPTH-1 to 0 by plain binary overflow. Push and pop in the same
// cycle leave the count unchanged; a push while full or a pop while empty
// is ignored.
module cmd_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next-state for storage, pointers and occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Queue state registers; reset empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/lcd_cmd_dispatch.sv
// Host-to-image-controller command dispatcher. Legal host opcodes are
// queued; one command at a time is strobed to the controller whenever it
// is not busy. After a strobe the controller's busy is ignored for one
// guard cycle, and a Write additionally blocks further issue until the
// controller reports the frame dump finished.
module lcd_cmd_dispatch
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    in_cmd,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [3:0]                    cmd,
    output logic                          cmd_valid,
    input  logic                          busy,
    input  logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_opcode,
    output logic [FRAME_W-1:0]            frame_cnt
);

    logic        fifo_push;
    logic        fifo_pop;
    logic [3:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;

    lcd_state_e          state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic                err_opcode_q, err_opcode_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && in_ready && opcode_legal(in_cmd);
    assign cmd        = cmd_q;
    assign cmd_valid  = cmd_valid_q;
    assign err_opcode = err_opcode_q;
    assign frame_cnt  = frame_cnt_q;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (in_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Illegal opcodes are dropped and flagged one cycle later, whether or
    // not the queue could have accepted them.
    always_comb begin
        err_opcode_d = in_valid && !opcode_legal(in_cmd);
    end

    // Dispatch FSM. The strobe and opcode are registered on the IDLE->ISSUE
    // transition, so cmd_valid is high exactly while the FSM sits in ISSUE
    // and cmd keeps the last issued opcode afterwards.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        fifo_pop    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!busy && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cmd_d       = fifo_head;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                state_d = (cmd_q == OP_WRITE) ? ST_WAIT_DONE : ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    if (frame_cnt_q != '1) begin
                        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and output registers; reset abandons any command in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            err_opcode_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            err_opcode_q <= err_opcode_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_lcd_cmd_dispatch.sv
// Scoreboard bench for lcd_cmd_dispatch. Accepted commands are queued by a
// reference model as they are offered; a monitor checks every strobe
// against that queue along with issue rules and frame counting.
module tb_lcd_cmd_dispatch;

    localparam int DEPTH = 8;
    localparam int FW    = 3;
    localparam int FMAX  = (1 << FW) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_cmd;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        done;
    logic [3:0]  fifo_count;
    logic        err_opcode;
    logic [FW-1:0] frame_cnt;

    lcd_cmd_dispatch #(
        .FIFO_DEPTH (DEPTH),
        .FRAME_W    (FW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_cmd     (in_cmd),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count),
        .err_opcode (err_opcode),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    int exp_q[$];
    bit outstanding = 1'b0;
    int armed_at    = 0;
    int frames      = 0;
    bit exp_err     = 1'b0;
    bit busy_last   = 1'b1;
    int last_strobe = -100;
    int popped;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: record accepted commands, expected error pulse and frame count.
    always @(posedge clk) begin
        cyc++;
        busy_last = busy;
        if (reset) begin
            exp_q.delete();
            outstanding = 1'b0;
            frames      = 0;
            exp_err     = 1'b0;
            last_strobe = -100;
        end else begin
            exp_err = in_valid && (in_cmd > 4'd11);
            if (in_valid && in_ready && (in_cmd <= 4'd11))
                exp_q.push_back(int'(in_cmd));
            if (outstanding && (cyc >= armed_at) && done) begin
                if (frames < FMAX) frames++;
                outstanding = 1'b0;
            end
        end
    end

    // Monitor: compare per-cycle outputs and every strobe with the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("err_opcode", int'(err_opcode), int'(exp_err));
            check("frame_cnt", int'(frame_cnt), frames);
            check("in_ready_vs_count", int'(in_ready), int'(fifo_count < DEPTH));
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got cmd_valid with cmd %0d, required no strobe (cycle %0d)", cmd, cyc);
                end else begin
                    popped = exp_q.pop_front();
                    check("cmd_order", int'(cmd), popped);
                    check("busy_at_issue", int'(busy_last), 0);
                    check("strobe_spacing_ge3", int'((cyc - last_strobe) >= 3), 1);
                    check("issue_during_write", int'(outstanding), 0);
                    last_strobe = cyc;
                    if (popped == 0) begin
                        outstanding = 1'b1;
                        armed_at    = cyc + 3;
                    end
                end
            end
        end
    end

    task automatic push_cmd(input logic [3:0] c);
        in_valid = 1'b1;
        in_cmd   = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Let every queued command issue, answering Writes with done.
    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !outstanding) begin
                ok = 1'b1;
                break;
            end
            busy = 1'b0;
            done = outstanding;
            @(negedge clk);
        end
        done = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d commands still pending, required 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        bit ok;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_cmd   = 4'd0;
        busy     = 1'b1;
        done     = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_fifo_count", int'(fifo_count), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_cmd", int'(cmd), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_err_opcode", int'(err_opcode), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);

        // Image-load period: busy held, a queued command must wait.
        repeat (10) @(negedge clk);
        push_cmd(4'd1);
        repeat (52) @(negedge clk);
        check("load_no_strobe", int'(cmd_valid), 0);
        check("load_count", int'(fifo_count), 1);
        busy = 1'b0;
        @(negedge clk);
        check("first_issue_valid", int'(cmd_valid), 1);
        check("first_issue_cmd", int'(cmd), 1);
        drain();

        // Fill the queue while busy; ninth push refused.
        busy = 1'b1;
        for (int c = 1; c <= 8; c++) push_cmd(4'(c));
        check("full_count", int'(fifo_count), 8);
        check("full_in_ready", int'(in_ready), 0);
        push_cmd(4'd9);
        check("full_refuse", int'(fifo_count), 8);
        drain();

        // Illegal opcode dropped and flagged.
        busy = 1'b1;
        push_cmd(4'd13);
        check("illegal_err", int'(err_opcode), 1);
        check("illegal_count", int'(fifo_count), 0);
        @(negedge clk);
        check("illegal_err_one_cycle", int'(err_opcode), 0);
        busy = 1'b0;
        repeat (6) @(negedge clk);
        check("illegal_not_issued", int'(fifo_count), 0);

        // Write blocks the next command until done.
        busy = 1'b1;
        push_cmd(4'd0);
        push_cmd(4'd5);
        busy = 1'b0;
        repeat (12) @(negedge clk);
        check("write_hold_count", int'(fifo_count), 1);
        check("write_hold_frames", int'(frame_cnt), 0);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("write_done_frames", int'(frame_cnt), 1);
        drain();

        // Push and pop in the same cycle at count 3.
        busy = 1'b1;
        push_cmd(4'd2);
        push_cmd(4'd3);
        push_cmd(4'd4);
        check("pp_count_before", int'(fifo_count), 3);
        busy     = 1'b0;
        in_valid = 1'b1;
        in_cmd   = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        busy     = 1'b1;
        check("pp_count_after", int'(fifo_count), 3);
        check("pp_strobe", int'(cmd_valid), 1);
        check("pp_cmd", int'(cmd), 2);
        drain();

        // Random traffic: pointer wrap, spurious done, illegal opcodes.
        repeat (1500) begin
            busy     = ($urandom_range(0, 9) < 4);
            in_valid = $urandom_range(0, 1) == 1;
            in_cmd   = 4'($urandom_range(0, 15));
            done     = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        done     = 1'b0;
        drain();

        // Frame counter saturation.
        for (int i = 0; i < 9; i++) begin
            push_cmd(4'd0);
            drain();
        end
        check("frame_saturate", int'(frame_cnt), FMAX);

        // Reset while waiting for a frame with commands queued.
        busy = 1'b0;
        push_cmd(4'd0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (outstanding && cyc >= armed_at) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_wait_done", int'(ok), 1);
        busy = 1'b1;
        for (int c = 1; c <= 4; c++) push_cmd(4'(c));
        check("midrst_count_before", int'(fifo_count), 4);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_count", int'(fifo_count), 0);
        check("midrst_frames", int'(frame_cnt), 0);
        check("midrst_cmd_valid", int'(cmd_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        repeat (5) begin
            @(negedge clk);
            check("midrst_no_strobe_busy", int'(cmd_valid), 0);
        end
        busy = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_still_empty", int'(fifo_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_cmd_dispatch.md
LCD_CMD_DISPATCH -- requirements
Module: lcd_cmd_dispatch

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, power of two, command queue depth.
REQ-002 SHALL have parameter FRAME_W, default 8, width of frame_cnt.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_cmd  input  4  host command opcode, 0..11 legal.
REQ-006 SHALL have port in_valid  input  1  host offers in_cmd this cycle.
REQ-007 SHALL have port in_ready  output  1  queue can accept; high when count < FIFO_DEPTH.
REQ-008 SHALL have port cmd  output  4  opcode to image controller, registered.
REQ-009 SHALL have port cmd_valid  output  1  one-cycle command strobe to controller, registered.
REQ-010 SHALL have port busy  input  1  controller busy; commands only issued when low.
REQ-011 SHALL have port done  input  1  controller one-cycle pulse: Write (opcode 0) frame dump finished.
REQ-012 SHALL have port fifo_count  output  log2(FIFO_DEPTH)+1  queued command count.
REQ-013 SHALL have port err_opcode  output  1  one-cycle pulse: illegal opcode dropped.
REQ-014 SHALL have port frame_cnt  output  FRAME_W  completed Write frames, saturating.

Function
REQ-015 SHALL enqueue in_cmd when in_valid && in_ready && in_cmd <= 11.
REQ-016 SHALL drop in_cmd > 11 (12..15) without enqueue, pulsing err_opcode the following cycle; in_ready unaffected.
REQ-017 SHALL implement the queue as circular FIFO, pointers wrap FIFO_DEPTH-1 -> 0, FIFO order preserved.
REQ-018 SHALL allow simultaneous push and pop in one cycle, fifo_count unchanged; push when full impossible (in_ready low).
REQ-019 SHALL run FSM states IDLE, ISSUE, GUARD, WAIT_DONE; reset state IDLE.
REQ-020 IDLE: if busy==0 and fifo_count>0, pop head -> ISSUE; else stay.
REQ-021 ISSUE: cmd_valid=1, cmd=popped opcode for exactly this one cycle -> GUARD.
REQ-022 GUARD: busy ignored for one cycle; next state WAIT_DONE if issued opcode==0, else IDLE.
REQ-023 WAIT_DONE: stay until done==1, then increment frame_cnt (saturate at all-ones) -> IDLE.
REQ-024 Latency: busy low with non-empty queue at cycle t -> cmd_valid high at cycle t+1; minimum spacing between strobes 3 cycles.
REQ-025 SHALL keep cmd_valid 0 in every state except ISSUE; cmd holds last issued opcode.
REQ-026 SHALL ignore done outside WAIT_DONE (no frame_cnt change).
REQ-027 SHALL not issue while busy==1 in IDLE, regardless of queue content.

Reset
REQ-028 On reset: state IDLE, FIFO empty, fifo_count 0, in_ready 1, cmd 0, cmd_valid 0, err_opcode 0, frame_cnt 0.
REQ-029 Reset mid-operation (any state) SHALL discard queued and in-flight commands; no cmd_valid after release until REQ-020 satisfied.
REQ-030 Out of reset, first issue SHALL wait for busy==0 (controller image load period).

Structure
REQ-031 Opcode constants (WRITE=0 .. MIRROR_Y=11, MAX_OPCODE=11) and FSM state encoding SHALL live in shared package lcd_pkg, also used by the image controller.
REQ-032 SHALL instantiate one sub-module cmd_fifo (parameterised depth/width, push/pop/count); FSM and counters in top.

Verification
REQ-033 Post-reset busy held 1 for 64 cycles, queue 1 (Shift_Up) -> no cmd_valid until busy falls; cmd_valid=1, cmd=1 the cycle after busy==0.
REQ-034 Push 8 commands 1..8 with busy=1 -> in_ready=0, fifo_count=8; 9th push refused; release busy -> cmds issue in order 1..8, strobes >=3 cycles apart.
REQ-035 Push 13 -> err_opcode pulse, fifo_count stays 0, nothing issued.
REQ-036 Queue 0 then 5, busy low -> cmd 0 issued; 5 held in WAIT_DONE despite busy==0; done pulse -> frame_cnt 1, then cmd 5 issued.
REQ-037 Simultaneous push and pop at fifo_count=3 -> fifo_count remains 3; pointer wrap after 20 pushes preserves order.
REQ-038 Assert reset during WAIT_DONE with 4 queued -> fifo_count 0, frame_cnt 0, cmd_valid 0 after release.
